// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS encoding constants.
// Provides the request kind enum, the ALU code values used by the CPU decoder,
// the primary opcodes and SPECIAL funct codes, and the encoder FSM state type.
package mips_pkg;

  typedef enum logic [3:0] {
    K_NOP   = 4'd0,
    K_R_ALU = 4'd1,
    K_SHIFT = 4'd2,
    K_JR    = 4'd3,
    K_J     = 4'd4,
    K_JAL   = 4'd5,
    K_BEQ   = 4'd6,
    K_BNE   = 4'd7,
    K_I_ALU = 4'd8,
    K_LUI   = 4'd9,
    K_LW    = 4'd10,
    K_SW    = 4'd11,
    K_LI    = 4'd12
  } kind_e;

  // ALU codes as the decoder produces them
  localparam logic [3:0] ALU_AND  = 4'd1;
  localparam logic [3:0] ALU_OR   = 4'd2;
  localparam logic [3:0] ALU_ADDU = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SUBU = 4'd6;
  localparam logic [3:0] ALU_SLT  = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_ADD  = 4'd11;
  localparam logic [3:0] ALU_SUB  = 4'd12;

  // primary opcodes
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;

  // SPECIAL funct codes
  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;

  typedef enum logic {S_IDLE, S_LO} state_e;

endpackage

// File: rtl/instr_encoder_if.sv
// instr_encoder_if: request channel into the instruction encoder.
// master drives in_valid and the decoded fields and observes in_ready;
// slave (the encoder) consumes the fields and drives in_ready.
interface instr_encoder_if;
  import mips_pkg::*;

  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_kind;
  logic [3:0]  in_alu_op;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [4:0]  in_shamt;
  logic [31:0] in_imm;

  modport master (output in_valid, in_kind, in_alu_op, in_rs, in_rt, in_rd,
                  in_shamt, in_imm,
                  input  in_ready);
  modport slave  (input  in_valid, in_kind, in_alu_op, in_rs, in_rt, in_rd,
                  in_shamt, in_imm,
                  output in_ready);
endinterface

// File: rtl/instr_encoder_pack.sv
// instr_pack: purely combinational packer from decoded fields to a MIPS word.
// Ports: kind/alu_op/rs/rt/rd/shamt/imm fields, lo_half selects the ORI half
// of an LI expansion (0 = LUI half); word is the encoded instruction and
// illegal flags a kind/ALU-code combination with no encoding (word is then 0).
module instr_pack
  import mips_pkg::*;
(
  input  logic [3:0]  kind,
  input  logic [3:0]  alu_op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [31:0] imm,
  input  logic        lo_half,
  output logic [31:0] word,
  output logic        illegal
);

  logic [5:0] code;

  // Select the opcode/funct for the kind, then assemble the word only when
  // the combination is legal so illegal requests always produce zero.
  always_comb begin
    word    = '0;
    illegal = 1'b0;
    code    = '0;
    case (kind)
      K_NOP: word = '0;
      K_R_ALU: begin
        case (alu_op)
          ALU_ADD:  code = F_ADD;
          ALU_ADDU: code = F_ADDU;
          ALU_SUB:  code = F_SUB;
          ALU_SUBU: code = F_SUBU;
          ALU_AND:  code = F_AND;
          ALU_OR:   code = F_OR;
          ALU_XOR:  code = F_XOR;
          ALU_NOR:  code = F_NOR;
          ALU_SLT:  code = F_SLT;
          default:  illegal = 1'b1;
        endcase
        if (!illegal) word = {OP_SPECIAL, rs, rt, rd, 5'd0, code};
      end
      K_SHIFT: begin
        case (alu_op)
          ALU_SLL: code = F_SLL;
          ALU_SRL: code = F_SRL;
          ALU_SRA: code = F_SRA;
          default: illegal = 1'b1;
        endcase
        if (!illegal) word = {OP_SPECIAL, 5'd0, rt, rd, shamt, code};
      end
      K_JR:  word = {OP_SPECIAL, rs, 15'd0, F_JR};
      K_J:   word = {OP_J, imm[25:0]};
      K_JAL: word = {OP_JAL, imm[25:0]};
      K_BEQ: word = {OP_BEQ, rs, rt, imm[15:0]};
      K_BNE: word = {OP_BNE, rs, rt, imm[15:0]};
      K_I_ALU: begin
        case (alu_op)
          ALU_ADD:  code = OP_ADDI;
          ALU_ADDU: code = OP_ADDIU;
          ALU_AND:  code = OP_ANDI;
          ALU_OR:   code = OP_ORI;
          ALU_XOR:  code = OP_XORI;
          default:  illegal = 1'b1;
        endcase
        if (!illegal) word = {code, rs, rt, imm[15:0]};
      end
      K_LUI: word = {OP_LUI, 5'd0, rt, imm[15:0]};
      K_LW:  word = {OP_LW, rs, rt, imm[15:0]};
      K_SW:  word = {OP_SW, rs, rt, imm[15:0]};
      // LI expands to LUI rt,hi followed by ORI rt,rt,lo
      K_LI:  word = lo_half ? {OP_ORI, rt, rt, imm[15:0]}
                            : {OP_LUI, 5'd0, rt, imm[31:16]};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: sequential MIPS encoder and instruction-memory writer.
// Ports: clk, rst_n (synchronous, active low), restart (clears pointer, count
// and err, aborts a pending LI), req (request channel, slave side),
// imem_wren/imem_addr/imem_data (registered RAM write port), words (words
// written), full (memory filled), err (sticky illegal-encoding flag).
module instr_encoder
  import mips_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               restart,
  instr_encoder_if.slave     req,
  output logic               imem_wren,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [31:0]        imem_data,
  output logic [ADDR_W:0]    words,
  output logic               full,
  output logic               err
);

  localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};

  state_e            state, state_nxt;
  logic [4:0]        li_rt;
  logic [15:0]       li_lo;
  logic [ADDR_W:0]   free_slots;
  logic [ADDR_W:0]   need;
  logic              accept;
  logic              do_write;
  logic              is_li;
  logic [3:0]        pk_kind;
  logic [4:0]        pk_rt;
  logic [31:0]       pk_imm;
  logic              pk_lo;
  logic [31:0]       pk_word;
  logic              pk_illegal;

  // Handshake: an LI needs two free slots so its ORI half can never be lost.
  // In S_LO the packer is fed from the saved LI fields instead of the bus.
  always_comb begin
    is_li        = (req.in_kind == K_LI);
    free_slots   = CAPACITY - words;
    need         = is_li ? (ADDR_W+1)'(2) : (ADDR_W+1)'(1);
    req.in_ready = rst_n && !restart && (state == S_IDLE) && (free_slots >= need);
    accept       = req.in_valid && req.in_ready;
    do_write     = accept || (state == S_LO);
    pk_kind      = req.in_kind;
    pk_rt        = req.in_rt;
    pk_imm       = req.in_imm;
    pk_lo        = 1'b0;
    if (state == S_LO) begin
      pk_kind = K_LI;
      pk_rt   = li_rt;
      pk_imm  = {16'd0, li_lo};
      pk_lo   = 1'b1;
    end
    full = (words == CAPACITY);
  end

  // Next-state logic: only an accepted LI leaves idle, and S_LO always
  // returns after its single ORI cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept && is_li) state_nxt = S_LO;
      S_LO:    state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register; restart aborts a pending ORI.
  always_ff @(posedge clk) begin
    if (!rst_n || restart) state <= S_IDLE;
    else                   state <= state_nxt;
  end

  instr_pack u_pack (
    .kind    (pk_kind),
    .alu_op  (req.in_alu_op),
    .rs      (req.in_rs),
    .rt      (pk_rt),
    .rd      (req.in_rd),
    .shamt   (req.in_shamt),
    .imm     (pk_imm),
    .lo_half (pk_lo),
    .word    (pk_word),
    .illegal (pk_illegal)
  );

  // Write port, pointer and status. The address is the word count before
  // the increment; the count saturates rather than wrapping. restart leaves
  // imem_data alone since the strobe is dropped anyway.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      imem_wren <= 1'b0;
      imem_addr <= '0;
      imem_data <= '0;
      words     <= '0;
      err       <= 1'b0;
      li_rt     <= '0;
      li_lo     <= '0;
    end else if (restart) begin
      imem_wren <= 1'b0;
      imem_addr <= '0;
      words     <= '0;
      err       <= 1'b0;
    end else begin
      imem_wren <= do_write;
      if (do_write) begin
        imem_addr <= words[ADDR_W-1:0];
        imem_data <= pk_word;
        err       <= err | pk_illegal;
        if (words != CAPACITY) words <= words + (ADDR_W+1)'(1);
      end
      if (accept && is_li) begin
        li_rt <= req.in_rt;
        li_lo <= req.in_imm[15:0];
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed-vector bench for instr_encoder.
// dut_a uses the default 10-bit address; dut_b uses ADDR_W=2 to reach full.
module tb_instr_encoder;
  import mips_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, restart_a, restart_b;
  logic        req_valid, use_b;
  logic [3:0]  req_kind, req_alu;
  logic [4:0]  req_rs, req_rt, req_rd, req_shamt;
  logic [31:0] req_imm;

  logic        a_wren, a_full, a_err;
  logic [9:0]  a_addr;
  logic [31:0] a_data;
  logic [10:0] a_words;
  logic        b_wren, b_full, b_err;
  logic [1:0]  b_addr;
  logic [31:0] b_data;
  logic [2:0]  b_words;

  int n_cmp = 0;
  int n_bad = 0;

  instr_encoder_if aif ();
  instr_encoder_if bif ();

  // One shared stimulus bus steered to either DUT
  assign aif.in_valid  = req_valid && !use_b;
  assign aif.in_kind   = req_kind;
  assign aif.in_alu_op = req_alu;
  assign aif.in_rs     = req_rs;
  assign aif.in_rt     = req_rt;
  assign aif.in_rd     = req_rd;
  assign aif.in_shamt  = req_shamt;
  assign aif.in_imm    = req_imm;
  assign bif.in_valid  = req_valid && use_b;
  assign bif.in_kind   = req_kind;
  assign bif.in_alu_op = req_alu;
  assign bif.in_rs     = req_rs;
  assign bif.in_rt     = req_rt;
  assign bif.in_rd     = req_rd;
  assign bif.in_shamt  = req_shamt;
  assign bif.in_imm    = req_imm;

  instr_encoder #(.ADDR_W(10)) dut_a (
    .clk(clk), .rst_n(rst_n), .restart(restart_a), .req(aif),
    .imem_wren(a_wren), .imem_addr(a_addr), .imem_data(a_data),
    .words(a_words), .full(a_full), .err(a_err)
  );

  instr_encoder #(.ADDR_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .restart(restart_b), .req(bif),
    .imem_wren(b_wren), .imem_addr(b_addr), .imem_data(b_data),
    .words(b_words), .full(b_full), .err(b_err)
  );

  typedef struct {
    logic [3:0]  kind;
    logic [3:0]  alu;
    logic [4:0]  rs, rt, rd, sh;
    logic [31:0] imm;
    logic [31:0] word;
  } vec_t;

  vec_t vecs[10];

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] kind, input logic [3:0] alu,
                               input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] rd, input logic [4:0] sh,
                               input logic [31:0] imm);
    req_kind  = kind;
    req_alu   = alu;
    req_rs    = rs;
    req_rt    = rt;
    req_rd    = rd;
    req_shamt = sh;
    req_imm   = imm;
    req_valid = 1'b1;
  endtask

  task automatic dropRequest();
    req_valid = 1'b0;
    req_kind  = K_NOP;
    req_rt    = 5'd0;
    req_imm   = 32'd0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0] = '{K_SHIFT, ALU_SRA,  5'd7,  5'd4, 5'd5, 5'd3, 32'h0,        32'h000428C3};
    vecs[1] = '{K_JR,    4'd0,     5'd31, 5'd3, 5'd4, 5'd0, 32'h0,        32'h03E00008};
    vecs[2] = '{K_BNE,   4'd0,     5'd1,  5'd2, 5'd0, 5'd0, 32'h0001FFFF, 32'h1422FFFF};
    vecs[3] = '{K_I_ALU, ALU_ADDU, 5'd2,  5'd3, 5'd0, 5'd0, 32'h00000010, 32'h24430010};
    vecs[4] = '{K_JAL,   4'd0,     5'd0,  5'd0, 5'd0, 5'd0, 32'hFFFFFFFF, 32'h0FFFFFFF};
    vecs[5] = '{K_LW,    4'd0,     5'd29, 5'd8, 5'd0, 5'd0, 32'h00000010, 32'h8FA80010};
    vecs[6] = '{K_R_ALU, ALU_SLT,  5'd4,  5'd5, 5'd6, 5'd0, 32'h0,        32'h0085302A};
    vecs[7] = '{K_LUI,   4'd0,     5'd9,  5'd1, 5'd0, 5'd0, 32'h0000BEEF, 32'h3C01BEEF};
    vecs[8] = '{K_R_ALU, ALU_SUB,  5'd1,  5'd2, 5'd3, 5'd0, 32'h0,        32'h00221822};
    vecs[9] = '{K_I_ALU, ALU_OR,   5'd0,  5'd1, 5'd0, 5'd0, 32'h000000FF, 32'h340100FF};

    rst_n = 1'b0; restart_a = 1'b0; restart_b = 1'b0; use_b = 1'b0;
    applyStimulus(K_NOP, 4'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_ready", 64'(aif.in_ready), 64'd0);
    checkOutput("rst_wren",  64'(a_wren),  64'd0);
    checkOutput("rst_addr",  64'(a_addr),  64'd0);
    checkOutput("rst_data",  64'(a_data),  64'd0);
    checkOutput("rst_words", 64'(a_words), 64'd0);
    checkOutput("rst_full",  64'(a_full),  64'd0);
    checkOutput("rst_err",   64'(a_err),   64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_ready", 64'(aif.in_ready), 64'd1);

    // R_ALU ADDU written one cycle after accept
    applyStimulus(K_R_ALU, ALU_ADDU, 5'd1, 5'd2, 5'd3, 5'd0, 32'd0);
    @(negedge clk);
    checkOutput("addu_wren",  64'(a_wren),  64'd1);
    checkOutput("addu_addr",  64'(a_addr),  64'd0);
    checkOutput("addu_data",  64'(a_data),  64'h00221821);
    checkOutput("addu_words", 64'(a_words), 64'd1);
    dropRequest();
    @(negedge clk);
    checkOutput("addu_wren_off", 64'(a_wren), 64'd0);
    restart_a = 1'b1;
    @(negedge clk);
    restart_a = 1'b0;
    checkOutput("restart_words", 64'(a_words), 64'd0);

    // LI expands to LUI then ORI, stalling one cycle
    applyStimulus(K_LI, 4'd0, 5'd0, 5'd8, 5'd0, 5'd0, 32'h12345678);
    @(negedge clk);
    checkOutput("li_lui_wren",  64'(a_wren), 64'd1);
    checkOutput("li_lui_addr",  64'(a_addr), 64'd0);
    checkOutput("li_lui_data",  64'(a_data), 64'h3C081234);
    checkOutput("li_busy_ready", 64'(aif.in_ready), 64'd0);
    dropRequest();
    @(negedge clk);
    checkOutput("li_ori_wren",  64'(a_wren), 64'd1);
    checkOutput("li_ori_addr",  64'(a_addr), 64'd1);
    checkOutput("li_ori_data",  64'(a_data), 64'h35085678);
    checkOutput("li_ready_back", 64'(aif.in_ready), 64'd1);
    checkOutput("li_words", 64'(a_words), 64'd2);

    // SW then J back to back
    applyStimulus(K_SW, 4'd0, 5'd29, 5'd31, 5'd0, 5'd0, 32'h00000004);
    @(negedge clk);
    checkOutput("sw_addr", 64'(a_addr), 64'd2);
    checkOutput("sw_data", 64'(a_data), 64'hAFBF0004);
    applyStimulus(K_J, 4'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'h00100000);
    @(negedge clk);
    checkOutput("j_wren", 64'(a_wren), 64'd1);
    checkOutput("j_addr", 64'(a_addr), 64'd3);
    checkOutput("j_data", 64'(a_data), 64'h08100000);

    // Table of further legal encodings, streamed one per cycle
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].kind, vecs[i].alu, vecs[i].rs, vecs[i].rt,
                    vecs[i].rd, vecs[i].sh, vecs[i].imm);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_data", i), 64'(a_data), 64'(vecs[i].word));
      checkOutput($sformatf("vec%0d_addr", i), 64'(a_addr), 64'(4 + i));
    end
    dropRequest();
    checkOutput("legal_err", 64'(a_err), 64'd0);
    checkOutput("legal_words", 64'(a_words), 64'd14);

    // Illegal combinations write zero and set sticky err
    applyStimulus(K_R_ALU, 4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 32'd0);
    @(negedge clk);
    checkOutput("ill_ralu_wren", 64'(a_wren), 64'd1);
    checkOutput("ill_ralu_data", 64'(a_data), 64'd0);
    checkOutput("ill_ralu_err",  64'(a_err),  64'd1);
    applyStimulus(4'd13, ALU_ADDU, 5'd1, 5'd2, 5'd3, 5'd0, 32'hFFFF);
    @(negedge clk);
    checkOutput("ill_kind_data", 64'(a_data), 64'd0);
    applyStimulus(K_I_ALU, ALU_SUB, 5'd1, 5'd2, 5'd0, 5'd0, 32'h1234);
    @(negedge clk);
    checkOutput("ill_ialu_data", 64'(a_data), 64'd0);
    applyStimulus(K_NOP, 4'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    @(negedge clk);
    checkOutput("err_sticky",  64'(a_err),   64'd1);
    checkOutput("ill_words",   64'(a_words), 64'd18);
    dropRequest();

    // restart right after LI accept drops the ORI half
    applyStimulus(K_LI, 4'd0, 5'd0, 5'd9, 5'd0, 5'd0, 32'hAAAA5555);
    @(negedge clk);
    checkOutput("rli_lui_data", 64'(a_data), 64'h3C09AAAA);
    restart_a = 1'b1;
    dropRequest();
    @(negedge clk);
    restart_a = 1'b0;
    checkOutput("rli_wren",  64'(a_wren),  64'd0);
    checkOutput("rli_words", 64'(a_words), 64'd0);
    checkOutput("rli_err",   64'(a_err),   64'd0);
    checkOutput("rli_addr",  64'(a_addr),  64'd0);
    @(negedge clk);
    checkOutput("rli_no_ori", 64'(a_wren), 64'd0);
    applyStimulus(K_R_ALU, ALU_ADDU, 5'd1, 5'd2, 5'd3, 5'd0, 32'd0);
    @(negedge clk);
    checkOutput("post_rst_addr",  64'(a_addr),  64'd0);
    checkOutput("post_rst_data",  64'(a_data),  64'h00221821);
    checkOutput("post_rst_words", 64'(a_words), 64'd1);
    dropRequest();

    // Small memory: three NOPs, then LI refused, NOP fills the last slot
    use_b = 1'b1;
    applyStimulus(K_NOP, 4'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("b_words3", 64'(b_words), 64'd3);
    checkOutput("b_full3",  64'(b_full),  64'd0);
    applyStimulus(K_LI, 4'd0, 5'd0, 5'd1, 5'd0, 5'd0, 32'h00010002);
    #1;
    checkOutput("b_li_refused", 64'(bif.in_ready), 64'd0);
    @(negedge clk);
    checkOutput("b_li_no_write", 64'(b_wren),  64'd0);
    checkOutput("b_li_words",    64'(b_words), 64'd3);
    applyStimulus(K_NOP, 4'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    #1;
    checkOutput("b_nop_ready", 64'(bif.in_ready), 64'd1);
    @(negedge clk);
    checkOutput("b_last_wren",  64'(b_wren),  64'd1);
    checkOutput("b_last_addr",  64'(b_addr),  64'd3);
    checkOutput("b_full",       64'(b_full),  64'd1);
    checkOutput("b_words4",     64'(b_words), 64'd4);
    checkOutput("b_full_ready", 64'(bif.in_ready), 64'd0);
    @(negedge clk);
    checkOutput("b_sat_wren",  64'(b_wren),  64'd0);
    checkOutput("b_sat_words", 64'(b_words), 64'd4);
    dropRequest();
    use_b = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential MIPS instruction encoder and instruction-memory writer: the write-side counterpart of the CPU decoder. Accepts one instruction request per handshake as decoded fields (kind, ALU op code, rs/rt/rd, shamt, immediate) and packs them into 32-bit MIPS words. Writes the words to consecutive instruction-memory addresses. Expands the LI pseudo-instruction into LUI+ORI over two cycles. Sits between the boot/program-load path and the instruction RAM write port.

## Interface
- ADDR_W, 10, instruction-memory word-address width.
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- restart  in  1  synchronous clear of write pointer, count and err; aborts pending LI.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_kind  in  4  0 NOP, 1 R_ALU, 2 SHIFT, 3 JR, 4 J, 5 JAL, 6 BEQ, 7 BNE, 8 I_ALU, 9 LUI, 10 LW, 11 SW, 12 LI; 13-15 illegal.
- in_alu_op  in  4  ALU code in the decoder encoding: AND 1, OR 2, ADDU 3, XOR 4, NOR 5, SUBU 6, SLT 7, SLL 8, SRL 9, SRA 10, ADD 11, SUB 12.
- in_rs, in_rt, in_rd  in  5 each  register fields.
- in_shamt  in  5  shift amount.
- in_imm  in  32  LI uses [31:0], J/JAL use [25:0], all others use [15:0].
- imem_wren  out  1  one-cycle write strobe.
- imem_addr  out  ADDR_W  write address.
- imem_data  out  32  encoded word.
- words  out  ADDR_W+1  words written since reset or restart.
- full  out  1  words == 2^ADDR_W.
- err  out  1  sticky; an illegal kind/alu_op combination was encoded.

## Operation
- FSM states:
  - S_IDLE → S_LO on accepted LI.
  - S_LO → S_IDLE after the ORI write.
  - Any state → S_IDLE on restart.
- in_ready = !rst_n_cycle && !restart && state==S_IDLE && free ≥ need, where need = 2 for LI and 1 otherwise, and free = 2^ADDR_W − words.
- Encodings:
  - R_ALU: op 0; funct by ALU code: ADD 20h, ADDU 21h, SUB 22h, SUBU 23h, AND 24h, OR 25h, XOR 26h, NOR 27h, SLT 2Ah.
  - SHIFT: op 0, rs = 0, uses rt/rd/shamt; funct SLL 00h, SRL 02h, SRA 03h.
  - JR: op 0, rs only, funct 08h.
  - J 02h, JAL 03h: addr = imm[25:0].
  - BEQ 04h, BNE 05h: rs, rt, imm[15:0].
  - I_ALU: ADD 08h, ADDU 09h, AND 0Ch, OR 0Dh, XOR 0Eh; rs, rt, imm[15:0].
  - LUI 0Fh: rs = 0. LW 23h, SW 2Bh: rs, rt, imm[15:0].
  - LI: LUI rt, imm[31:16], then ORI rt, rt, imm[15:0].
  - NOP: 00000000h.
- Illegal combination (ALU code not listed for that kind, or kind 13-15): write 00000000h and set err. The word still consumes a slot.
- imem_addr = words[ADDR_W-1:0] at the time of the write. words increments once per write and saturates at 2^ADDR_W; there is no wrap.

## Timing
- Reset values: in_ready 0, imem_wren 0, imem_addr 0, imem_data 0, words 0, full 0, err 0, state S_IDLE.
- Single-word request: accepted at edge T; imem_wren/addr/data are registered and valid in cycle T+1. Back-to-back accepts sustain 1 word per cycle.
- LI accepted at T:
  - LUI word at T+1 and ORI word at T+2 (address +1).
  - in_ready is 0 during T+1 and returns to 1 at T+2.
- restart:
  - Has priority over in_valid and over the pending ORI: the ORI is not written.
  - words, err and imem_addr clear on the next edge; imem_wren is 0 in the following cycle.
  - A write strobe already registered in the restart cycle still completes.
- full rises in the cycle of the write that fills the last slot. With one slot free, LI is refused (in_ready 0) while non-LI requests are still accepted.

## Structure
- Shared package `mips_pkg`:
  - in_kind enum.
  - ALU code constants, shared with the decoder.
  - opcode and funct constants.
- One combinational sub-module, `instr_pack` (kind, alu_op, fields, lo_half → word, illegal). The top level holds the FSM, pointer, count and handshake.

## Test plan
- R_ALU ADDU rs=1 rt=2 rd=3 → imem_data 00221821h at addr 0, one cycle after accept.
- LI rt=8 imm=12345678h → 3C081234h at addr 0, then 35085678h at addr 1; in_ready 0 for one cycle.
- SW rs=29 rt=31 imm=0004h, then J imm=0100000h back-to-back → AFBF0004h then 08100000h on consecutive cycles.
- R_ALU with alu_op=0 → 00000000h written, err=1 and stays 1 until restart.
- ADDR_W=2: three NOPs, then LI offered → in_ready 0; NOP offered → accepted, full=1, in_ready 0.
- restart asserted in the cycle after LI accept → no ORI written, words=0; the next request is written at addr 0.
